// File: rtl/lcd_nibble_writer.sv
// Byte-level front end for a PCF8574-backed HD44780 LCD: splits each request into EN-pulsed
// nibble writes, drives the i2c_master single-byte handshake, then waits out the execution time.
module lcd_nibble_writer #(
  parameter int unsigned CMD_DELAY     = 5_000,
  parameter int unsigned LONG_DELAY    = 200_000,
  parameter int unsigned START_TIMEOUT = 65_535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_nibble,
  input  logic [7:0] req_data,
  input  logic       backlight,
  output logic       i2c_ena,
  output logic [7:0] i2c_data_wr,
  input  logic       i2c_busy,
  input  logic       i2c_ack_error,
  output logic       err_nack,
  output logic       err_timeout
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitLo, StHold} state_e;

  state_e      state_q, state_d;
  logic        rs_q, rs_d, bl_q, bl_d, nib_q, nib_d, long_q, long_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  xfer_q, xfer_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ready_q, ready_d, ena_q, ena_d;
  logic [7:0]  wr_q, wr_d;
  logic        nack_q, nack_d, tmo_q, tmo_d;
  logic        accept, last_xfer;
  logic [31:0] hold_cnt;

  // Transfer index: bit 1 selects the low nibble, bit 0 drops EN.
  function automatic logic [7:0] pcf_byte(input logic [7:0] data, input logic [1:0] idx,
                                          input logic bl, input logic rs);
    logic [3:0] nib;
    nib = idx[1] ? data[3:0] : data[7:4];
    return {nib, bl, ~idx[0], 1'b0, rs};
  endfunction

  assign accept    = req_valid & ready_q;
  assign last_xfer = nib_q ? (xfer_q == 2'd1) : (xfer_q == 2'd3);
  assign hold_cnt  = long_q ? 32'(LONG_DELAY) : 32'(CMD_DELAY);

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    bl_d    = bl_q;
    nib_d   = nib_q;
    long_d  = long_q;
    data_d  = data_q;
    xfer_d  = xfer_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    nack_d  = nack_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rs_d    = req_rs;
          bl_d    = backlight;
          nib_d   = req_nibble;
          data_d  = req_data;
          long_d  = ~req_rs & ~req_nibble & (req_data inside {8'h01, 8'h02, 8'h03});
          nack_d  = 1'b0;
          tmo_d   = 1'b0;
          xfer_d  = 2'd0;
          cnt_d   = '0;
          wr_d    = pcf_byte(req_data, 2'd0, backlight, req_rs);
          state_d = StSend;
        end
      end
      StSend: begin
        if (i2c_busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == 32'(START_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          cnt_d   = hold_cnt;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitLo: begin
        if (!i2c_busy) begin
          if (i2c_ack_error) nack_d = 1'b1;
          if (last_xfer) begin
            cnt_d   = hold_cnt;
            state_d = StHold;
          end else begin
            xfer_d  = xfer_q + 2'd1;
            wr_d    = pcf_byte(data_q, xfer_q + 2'd1, bl_q, rs_q);
            cnt_d   = '0;
            state_d = StSend;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are registered from the next state so they switch on the decision edge.
    ready_d = (state_d == StIdle);
    ena_d   = (state_d == StSend);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rs_q    <= 1'b0;
      bl_q    <= 1'b0;
      nib_q   <= 1'b0;
      long_q  <= 1'b0;
      data_q  <= 8'h00;
      xfer_q  <= 2'd0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ena_q   <= 1'b0;
      wr_q    <= 8'h00;
      nack_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      bl_q    <= bl_d;
      nib_q   <= nib_d;
      long_q  <= long_d;
      data_q  <= data_d;
      xfer_q  <= xfer_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ena_q   <= ena_d;
      wr_q    <= wr_d;
      nack_q  <= nack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready   = ready_q;
  assign i2c_ena     = ena_q;
  assign i2c_data_wr = wr_q;
  assign err_nack    = nack_q;
  assign err_timeout = tmo_q;

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Byte-level front end for a PCF8574-backed HD44780 character LCD. It accepts one command or data byte per request, splits it into the four I2C byte writes that pulse the LCD EN line (high nibble EN=1, high nibble EN=0, low nibble EN=1, low nibble EN=0), and drives the `i2c_master` single-byte write handshake for each. It then holds off the next request for the HD44780 execution time. It sits between the LCD init/message sequencer (upstream) and `i2c_master` (downstream).

## Interface
Parameters:
- `CMD_DELAY`, 5_000: post-request hold-off in clk cycles. This is 50 µs at 100 MHz.
- `LONG_DELAY`, 200_000: hold-off after a clear (0x01) or home (0x02/0x03) command with rs=0. This is 2 ms.
- `START_TIMEOUT`, 65_535: maximum cycles to wait for `i2c_busy` to rise after `i2c_ena` is asserted.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_rs` in 1: LCD RS. 0 = command, 1 = data.
- `req_nibble` in 1: when 1, send only `req_data[7:4]` as one EN pulse (2 transfers). Used for the 8-bit reset and 4-bit mode entry steps.
- `req_data` in 8: byte to send.
- `backlight` in 1: backlight bit, sampled at accept.
- `i2c_ena` out 1: to `i2c_master.ena`.
- `i2c_data_wr` out 8: to `i2c_master.data_wr`.
- `i2c_busy` in 1: from `i2c_master.busy`.
- `i2c_ack_error` in 1: from `i2c_master.ack_error`.
- `err_nack` out 1: sticky. A transfer ended with `i2c_ack_error`=1.
- `err_timeout` out 1: sticky. `i2c_busy` did not rise within `START_TIMEOUT`.

## Operation
- PCF8574 byte format: {nibble[3:0], bl, en, rw=0, rs}. rs and bl are registered at accept.
- Transfer list:
  - Full byte: {hi,1}, {hi,0}, {lo,1}, {lo,0}.
  - Nibble request: {hi,1}, {hi,0}.
- Accept: `req_valid & req_ready` at a rising edge. Request fields are captured at that edge. Both error flags clear on accept.
- States:
  - IDLE: `req_ready`=1. Goes to SEND on accept.
  - SEND: `i2c_ena`=1 and `i2c_data_wr` = current transfer byte. Goes to WAIT_LO on the edge where `i2c_busy`=1 is sampled; `i2c_ena` falls on that same edge. If `START_TIMEOUT` cycles elapse in SEND without busy, set `err_timeout`, drop `i2c_ena`, and go to HOLD. Remaining transfers are abandoned.
  - WAIT_LO: `i2c_ena`=0. On the edge where `i2c_busy`=0 is sampled, the transfer is complete. If `i2c_ack_error`=1 on that edge, set `err_nack`; the sequence continues regardless. Go to SEND if transfers remain, else to HOLD.
  - HOLD: a down-counter is loaded on entry, then decrements. Return to IDLE on the edge after it reaches 0.
- HOLD count: `LONG_DELAY` when rs=0, req_nibble=0 and data ∈ {0x01, 0x02, 0x03}. Otherwise `CMD_DELAY`.
- `i2c_data_wr` holds its last value outside SEND.
- Counter width: the delay and timeout counters are wide enough for the larger of `LONG_DELAY` and `START_TIMEOUT`; 32 bits covers this.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, then 1 in IDLE from the first edge after release. `i2c_ena`=0, `i2c_data_wr`=0x00, `err_nack`=0, `err_timeout`=0. State is IDLE.
- `req_ready` drops on the accept edge. It returns high on the edge HOLD exits, so it is high for a full cycle before the next accept.
- `i2c_ena` rises on the accept edge for the first transfer, and on the completion edge for each later transfer. There are no idle cycles between transfers beyond the master's own latency.
- `i2c_busy` may take up to one master quarter-period to rise after `i2c_ena`. At 100 MHz and 50 kHz this is 500 cycles, which is well inside `START_TIMEOUT`.
- `rst` asserted mid-sequence forces IDLE and `i2c_ena`=0 immediately, without a clock edge. Any I2C frame already in flight is not waited for.
- `req_valid` asserted outside IDLE is ignored and not queued.
- Busy rising and falling within one sampled cycle cannot occur, because the master holds busy high for a whole frame.

## Test plan
- **Full data byte.** Use a behavioural `i2c_master` model. Request rs=1, data=0x48 ('H'), bl=1. Required: four transfers of 0x4D, 0x49, 0x8D, 0x89 in order. Then `req_ready` stays low for `CMD_DELAY` cycles after the last busy fall. Both error flags stay 0.
- **Nibble request.** Request req_nibble=1, rs=0, data=0x30, bl=1. Required: exactly two transfers, 0x3C then 0x38, followed by a `CMD_DELAY` hold-off.
- **Clear display.** Request rs=0, data=0x01. Required: transfers 0x0C, 0x08, 0x1C, 0x18, then a hold-off of `LONG_DELAY`. Repeat with data=0x0C and confirm a hold-off of `CMD_DELAY`.
- **NACK.** Make the model return ack_error=1 on transfer 2. Required: `err_nack`=1 after that transfer. All four transfers are still issued. The flag clears on the next accept.
- **Start timeout.** Keep `i2c_busy` stuck at 0. Required: `i2c_ena` is high for exactly `START_TIMEOUT` cycles, then `err_timeout`=1, then the block passes through HOLD to IDLE.
- **Reset and ignored requests.** Assert `rst` during transfer 3. Required: `i2c_ena`=0 immediately, and after release `req_ready`=1 with the error flags at 0. Separately, pulse `req_valid` during HOLD. Required: no transfer is issued.
